reorder_buffer_commit: RTL and testbench

//   In-order commit unit; drives the architectural register file commit port.

---
 rtl/reorder_buffer_commit.sv | 101 ++++++++++
 tb/tb_reorder_buffer_commit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_commit.sv
// reorder_buffer_commit: in-order commit unit for the rename buffer.
// Entries are allocated at the tail by dispatch, marked finished by execution,
// and retire one per cycle from the head toward the ARF/rename table.
// Optional feature macro: ROB_PERF_CNT_EN adds a 64-bit commit counter port.
module reorder_buffer_commit #(
    parameter int RRF_NUM = 64,
    parameter int RRF_SEL = 6,
    parameter int REG_SEL = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               dp_en_i,
    input  logic               dp_dst_en_i,
    input  logic [REG_SEL-1:0] dp_dst_num_i,
    output logic               dp_ready_o,
    output logic [RRF_SEL-1:0] dp_rrftag_o,
    input  logic               fin_en_i,
    input  logic [RRF_SEL-1:0] fin_rrftag_i,
    output logic               commit_valid_o,
    output logic               completed_we_o,
    output logic [REG_SEL-1:0] completed_dst_num_o,
    output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
    output logic [RRF_SEL:0]   rob_count_o
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [63:0]        perf_commit_cnt_o
`endif
);

    localparam logic [RRF_SEL-1:0] TAG_ONE    = RRF_SEL'(1);
    localparam logic [RRF_SEL:0]   FULL_COUNT = (RRF_SEL + 1)'(RRF_NUM);

    logic [RRF_NUM-1:0] valid;
    logic [RRF_NUM-1:0] finished;
    logic [RRF_NUM-1:0] dst_en;
    logic [REG_SEL-1:0] dst_num [RRF_NUM];
    logic [RRF_SEL-1:0] head;
    logic [RRF_SEL-1:0] tail;
    logic [RRF_SEL:0]   count;

    logic dispatch;
    logic commit;

    // Handshake and commit port decoded from registered state only; no bypass.
    assign dp_ready_o             = (count != FULL_COUNT);
    assign dispatch               = dp_en_i & dp_ready_o;
    assign commit                 = valid[head] & finished[head];
    assign commit_valid_o         = commit;
    assign completed_we_o         = commit & dst_en[head];
    assign completed_dst_num_o    = dst_num[head];
    assign completed_dst_rrftag_o = head;
    assign dp_rrftag_o            = tail;
    assign rob_count_o            = count;

    // Entry status and pointers; later assignments win, so commit clears
    // beat a finish on the head and a dispatch beats a finish on the tail.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid    <= '0;
            finished <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (fin_en_i && valid[fin_rrftag_i]) begin
                finished[fin_rrftag_i] <= 1'b1;
            end
            if (commit) begin
                valid[head]    <= 1'b0;
                finished[head] <= 1'b0;
                head           <= head + TAG_ONE;
            end
            if (dispatch) begin
                valid[tail]    <= 1'b1;
                finished[tail] <= 1'b0;
                tail           <= tail + TAG_ONE;
            end
            count <= count + {{RRF_SEL{1'b0}}, dispatch} - {{RRF_SEL{1'b0}}, commit};
        end
    end

    // Destination payload captured on allocation; writes to x0 never enable the ARF.
    always_ff @(posedge clk_i) begin
        if (dispatch) begin
            dst_en[tail]  <= dp_dst_en_i && (dp_dst_num_i != '0);
            dst_num[tail] <= dp_dst_num_i;
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Free-running count of retired instructions, wrapping at 2^64.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_commit_cnt_o <= '0;
        end else if (commit) begin
            perf_commit_cnt_o <= perf_commit_cnt_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer_commit.sv
// tb_reorder_buffer_commit: directed vectors for the in-order commit unit.
module tb_reorder_buffer_commit;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       dp_en_i = 1'b0;
    logic       dp_dst_en_i = 1'b0;
    logic [4:0] dp_dst_num_i = '0;
    logic       dp_ready_o;
    logic [5:0] dp_rrftag_o;
    logic       fin_en_i = 1'b0;
    logic [5:0] fin_rrftag_i = '0;
    logic       commit_valid_o;
    logic       completed_we_o;
    logic [4:0] completed_dst_num_o;
    logic [5:0] completed_dst_rrftag_o;
    logic [6:0] rob_count_o;
`ifdef ROB_PERF_CNT_EN
    logic [63:0] perf_commit_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    reorder_buffer_commit dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .dp_en_i                (dp_en_i),
        .dp_dst_en_i            (dp_dst_en_i),
        .dp_dst_num_i           (dp_dst_num_i),
        .dp_ready_o             (dp_ready_o),
        .dp_rrftag_o            (dp_rrftag_o),
        .fin_en_i               (fin_en_i),
        .fin_rrftag_i           (fin_rrftag_i),
        .commit_valid_o         (commit_valid_o),
        .completed_we_o         (completed_we_o),
        .completed_dst_num_o    (completed_dst_num_o),
        .completed_dst_rrftag_o (completed_dst_rrftag_o),
        .rob_count_o            (rob_count_o)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt_o      (perf_commit_cnt_o)
`endif
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the edge.
    task automatic applyStimulus(input logic dp_en, input logic dst_en, input logic [4:0] dst_num,
                                 input logic fin_en, input logic [5:0] fin_tag);
        dp_en_i      = dp_en;
        dp_dst_en_i  = dst_en;
        dp_dst_num_i = dst_num;
        fin_en_i     = fin_en;
        fin_rrftag_i = fin_tag;
        @(posedge clk_i);
        #1;
        dp_en_i  = 1'b0;
        fin_en_i = 1'b0;
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        reset_i = 1'b0;
    endtask

    initial begin
        // 1: reset state
        doReset();
        doReset();
        checkOutput("rst_ready", dp_ready_o, 1);
        checkOutput("rst_tag", dp_rrftag_o, 0);
        checkOutput("rst_cv", commit_valid_o, 0);
        checkOutput("rst_we", completed_we_o, 0);
        checkOutput("rst_head", completed_dst_rrftag_o, 0);
        checkOutput("rst_count", rob_count_o, 0);

        // 2: out-of-order finish, in-order commit, x0 destination
        applyStimulus(1, 1, 5'd5, 0, 6'd0);
        applyStimulus(1, 1, 5'd6, 0, 6'd0);
        applyStimulus(1, 1, 5'd0, 0, 6'd0);
        checkOutput("t2_count3", rob_count_o, 3);
        checkOutput("t2_tail3", dp_rrftag_o, 3);
        applyStimulus(0, 0, 5'd0, 1, 6'd1);
        checkOutput("t2_nocommit", commit_valid_o, 0);
        applyStimulus(0, 0, 5'd0, 1, 6'd0);
        checkOutput("t2_cv0", commit_valid_o, 1);
        checkOutput("t2_we0", completed_we_o, 1);
        checkOutput("t2_num0", completed_dst_num_o, 5);
        checkOutput("t2_tag0", completed_dst_rrftag_o, 0);
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        checkOutput("t2_cv1", commit_valid_o, 1);
        checkOutput("t2_we1", completed_we_o, 1);
        checkOutput("t2_num1", completed_dst_num_o, 6);
        checkOutput("t2_tag1", completed_dst_rrftag_o, 1);
        checkOutput("t2_count2", rob_count_o, 2);
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        checkOutput("t2_cv_wait", commit_valid_o, 0);
        checkOutput("t2_count1", rob_count_o, 1);
        applyStimulus(0, 0, 5'd0, 1, 6'd2);
        checkOutput("t2_cv2", commit_valid_o, 1);
        checkOutput("t2_we2_x0", completed_we_o, 0);
        checkOutput("t2_tag2", completed_dst_rrftag_o, 2);
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        checkOutput("t2_empty_cv", commit_valid_o, 0);
        checkOutput("t2_empty_cnt", rob_count_o, 0);

        // 3: fill to 64, overflow ignored, commit does not bypass into dispatch
        doReset();
        for (int i = 0; i < 64; i++) applyStimulus(1, 1, 5'(i), 0, 6'd0);
        checkOutput("t3_full_rdy", dp_ready_o, 0);
        checkOutput("t3_full_cnt", rob_count_o, 64);
        applyStimulus(1, 1, 5'd9, 0, 6'd0);
        checkOutput("t3_ovf_cnt", rob_count_o, 64);
        checkOutput("t3_ovf_tail", dp_rrftag_o, 0);
        applyStimulus(0, 0, 5'd0, 1, 6'd0);
        checkOutput("t3_cv", commit_valid_o, 1);
        checkOutput("t3_still_full", dp_ready_o, 0);
        applyStimulus(1, 1, 5'd9, 0, 6'd0);
        checkOutput("t3_reopen_rdy", dp_ready_o, 1);
        checkOutput("t3_reopen_cnt", rob_count_o, 63);
        checkOutput("t3_no_bypass", dp_rrftag_o, 0);

        // 4: pointer wrap with streaming dispatch/finish/commit
        doReset();
        for (int i = 0; i < 70; i++) begin
            if (i == 63) checkOutput("t4_tail63", dp_rrftag_o, 63);
            if (i == 64) begin
                checkOutput("t4_tail0", dp_rrftag_o, 0);
                checkOutput("t4_count", rob_count_o, 2);
                checkOutput("t4_head62", completed_dst_rrftag_o, 62);
                checkOutput("t4_cv62", commit_valid_o, 1);
            end
            if (i == 65) begin
                checkOutput("t4_head63", completed_dst_rrftag_o, 63);
                checkOutput("t4_num63", completed_dst_num_o, 31);
                checkOutput("t4_we63", completed_we_o, 1);
            end
            if (i == 66) begin
                checkOutput("t4_head0", completed_dst_rrftag_o, 0);
                checkOutput("t4_cv0", commit_valid_o, 1);
                checkOutput("t4_we0_x0", completed_we_o, 0);
            end
            applyStimulus(1, 1, 5'(i), i > 0, (i > 0) ? 6'(i - 1) : 6'd0);
        end

        // 5: finish to an invalid tag is dropped; dispatch beats same-cycle finish
        doReset();
        applyStimulus(0, 0, 5'd0, 1, 6'd10);
        for (int i = 0; i < 11; i++) applyStimulus(1, 1, 5'd3, 0, 6'd0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 5'd0, 1, 6'(i));
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        checkOutput("t5_cnt1", rob_count_o, 1);
        checkOutput("t5_head10", completed_dst_rrftag_o, 10);
        checkOutput("t5_stale_fin", commit_valid_o, 0);
        applyStimulus(0, 0, 5'd0, 1, 6'd10);
        checkOutput("t5_cv10", commit_valid_o, 1);
        applyStimulus(1, 1, 5'd7, 1, 6'd11);
        checkOutput("t5_cnt_sw", rob_count_o, 1);
        checkOutput("t5_head11", completed_dst_rrftag_o, 11);
        checkOutput("t5_disp_wins", commit_valid_o, 0);

        // 6: reset with entries in flight, then commit counting
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 5'd2, 0, 6'd0);
        checkOutput("t6_cnt5", rob_count_o, 5);
        doReset();
        checkOutput("t6_cnt0", rob_count_o, 0);
        checkOutput("t6_cv", commit_valid_o, 0);
        checkOutput("t6_tail", dp_rrftag_o, 0);
        checkOutput("t6_ready", dp_ready_o, 1);
        applyStimulus(1, 1, 5'd1, 0, 6'd0);
        applyStimulus(1, 1, 5'd2, 1, 6'd0);
        applyStimulus(1, 1, 5'd3, 1, 6'd1);
        applyStimulus(0, 0, 5'd0, 1, 6'd2);
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        applyStimulus(0, 0, 5'd0, 0, 6'd0);
        checkOutput("t6_drained", rob_count_o, 0);
        checkOutput("t6_head3", completed_dst_rrftag_o, 3);
`ifdef ROB_PERF_CNT_EN
        checkOutput("t6_perf3", perf_commit_cnt_o, 3);
        doReset();
        checkOutput("t6_perf_rst", perf_commit_cnt_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
